lcd_char_writer: RTL
====================

Name: lcd_char_writer

Overview:
- Downstream physical stage for the Spartan-3E character LCD, run in 4-bit mode.
- Replaces free-running, counter-sliced bit-banging. Upstream display logic (adder/sum formatter, message sequencers) presents one command or data byte per valid/ready handshake.
- The block runs the power-on init nibbles, splits each byte into two nibbles and generates E-strobe setup/pulse/hold plus post-command wait timing.
- Drives the LCD pins directly.

Parameters:
- T_POWERUP, 750000, cycles idle after reset before first init nibble (15 ms @ 50 MHz)
- T_SETUP, 2, cycles RS/data stable before E rises
- T_PULSE, 12, cycles E held high
- T_HOLD, 1, cycles RS/data held after E falls
- T_NIBBLE, 50, gap cycles between high and low nibble of one byte
- T_CMD, 2000, wait cycles after a normal byte or init nibble 3/4
- T_CLEAR, 82000, wait cycles after command 0x01 or 0x02 (clear/home)
- T_INIT1, 205000, wait cycles after init nibble 1
- T_INIT2, 5000, wait cycles after init nibble 2
- CW, 20, timer width; every T_* parameter must be ≥1 and < 2^CW

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  upstream has a byte to write
- req_ready  out  1  block can accept a byte this cycle
- req_rs  in  1  0 = command, 1 = character data
- req_data  in  8  byte to write
- init_done  out  1  power-on nibble sequence complete; stays high until reset
- sf_e  out  1  StrataFlash disable
- lcd_e  out  1  LCD enable strobe
- lcd_rs  out  1  LCD register select
- lcd_rw  out  1  LCD read/write; constant 0
- lcd_d  out  4  LCD data nibble (DB7..DB4)

Behaviour:
- Clock and reset: one clock `clk`; `rst_n` is asynchronous and active-low.
- Reset values:
  - lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_d=0, req_ready=0, init_done=0, sf_e=1.
  - State = PWR_WAIT, timer loaded with T_POWERUP-1.
- Reset asserted mid-operation: all of the above apply immediately, an in-flight byte is dropped, and the init sequence reruns in full.
- All outputs are registered.
- Timer: each timed phase loads the timer with N-1 on entry, decrements every cycle, and exits on the cycle the timer is 0. A phase of length N lasts exactly N clocks.
- States: PWR_WAIT → SETUP → PULSE → HOLD → WAIT → (GAP → SETUP ...) → IDLE.
  - SETUP: lcd_e=0, lcd_rs and lcd_d driven with the current nibble, T_SETUP cycles.
  - PULSE: lcd_e=1, T_PULSE cycles.
  - HOLD: lcd_e=0, rs/d unchanged, T_HOLD cycles.
  - GAP (after the high nibble only): T_NIBBLE cycles, then SETUP with the low nibble.
  - WAIT (after the final nibble): duration selected as below, then next init nibble or IDLE.
- Init sequence (after PWR_WAIT):
  - Four single-nibble writes, rs=0: 0x3, 0x3, 0x3, 0x2.
  - Post waits: T_INIT1, T_INIT2, T_CMD, T_CMD.
  - After the 4th wait, init_done goes high and the state goes to IDLE.
  - Function set, entry mode, display on and clear are issued by upstream as normal commands.
- req_ready=1 only in IDLE with init_done=1.
- Accept condition: req_valid & req_ready.
  - Capture req_rs and req_data.
  - req_ready drops the next cycle; SETUP is entered with the high nibble data[7:4].
- Byte write order: high nibble, GAP, low nibble data[3:0]. rs is held constant for the whole byte.
- Post-byte WAIT length: T_CLEAR if rs=0 and data is 0x01 or 0x02, else T_CMD.
- Latency: accept to first E rise = 1 + T_SETUP cycles.
- Throughput: a normal byte occupies 2·(T_SETUP+T_PULSE+T_HOLD) + T_NIBBLE + T_CMD cycles plus 1 accept cycle before req_ready returns.
- Upstream input changes while busy are ignored; a req_valid held high through busy is accepted on the first ready cycle.
- After HOLD/WAIT completes, lcd_d and lcd_rs keep their last values. lcd_e is never high outside PULSE.

Test Plan (sim params T_POWERUP=10, T_SETUP=2, T_PULSE=3, T_HOLD=1, T_NIBBLE=4, T_CMD=6, T_CLEAR=20, T_INIT1=8, T_INIT2=5):
- Reset release, req_valid=0:
  - no E pulse for 10 cycles;
  - then 4 E pulses, each 3 cycles wide, with lcd_d=3,3,3,2 and lcd_rs=0;
  - init_done and req_ready rise after the last wait;
  - lcd_rw=0 and sf_e=1 throughout.
- After init, send rs=1 data=0x41 ('A'):
  - E rises 3 cycles after accept with lcd_d=4, lcd_rs=1;
  - second pulse has lcd_d=1;
  - gap between E falling and the next SETUP is 1+4 cycles;
  - req_ready returns after a 6-cycle wait.
- Send rs=0 data=0x01 → post-byte wait is 20 cycles. Send rs=1 data=0x01 → wait is 6 cycles.
- Hold req_valid high with bytes 0x28, 0x06, 0x0C back-to-back → each accepted exactly once, in order; nibbles 2,8,0,6,0,C on lcd_d.
- Assert rst_n=0 during the PULSE of a low nibble:
  - lcd_e=0 and req_ready=0 on the same edge, init_done=0;
  - after release, the full init sequence repeats.
- Toggle req_data/req_rs while busy → emitted nibbles match the captured byte, not the new values.

Source files
------------

// File: rtl/lcd_char_writer_if.sv
// ============================================================================
// Module      : lcd_char_writer_if
// Description : Byte-write handshake between upstream display logic and the
//               LCD character writer (one command/data byte per transfer).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lcd_char_writer_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_rs;
  logic [7:0] req_data;

  modport master (
    output req_valid,
    output req_rs,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_rs,
    input  req_data,
    output req_ready
  );
endinterface

`default_nettype wire

// File: rtl/lcd_char_writer.sv
// ============================================================================
// Module      : lcd_char_writer
// Description : 4-bit mode physical writer for the Spartan-3E character LCD:
//               power-on init nibbles, byte splitting and E-strobe timing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_char_writer #(
  parameter int T_POWERUP = 750000,
  parameter int T_SETUP   = 2,
  parameter int T_PULSE   = 12,
  parameter int T_HOLD    = 1,
  parameter int T_NIBBLE  = 50,
  parameter int T_CMD     = 2000,
  parameter int T_CLEAR   = 82000,
  parameter int T_INIT1   = 205000,
  parameter int T_INIT2   = 5000,
  parameter int CW        = 20
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  lcd_char_writer_if.slave up,
  output logic             init_done,
  output logic             sf_e,
  output logic             lcd_e,
  output logic             lcd_rs,
  output logic             lcd_rw,
  output logic [3:0]       lcd_d
);

  // Timers count N-1 down to 0, so each phase lasts exactly N clocks.
  localparam logic [CW-1:0] c_powerup = CW'(T_POWERUP - 1);
  localparam logic [CW-1:0] c_setup   = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] c_pulse   = CW'(T_PULSE - 1);
  localparam logic [CW-1:0] c_hold    = CW'(T_HOLD - 1);
  localparam logic [CW-1:0] c_nibble  = CW'(T_NIBBLE - 1);
  localparam logic [CW-1:0] c_cmd     = CW'(T_CMD - 1);
  localparam logic [CW-1:0] c_clear   = CW'(T_CLEAR - 1);
  localparam logic [CW-1:0] c_init1   = CW'(T_INIT1 - 1);
  localparam logic [CW-1:0] c_init2   = CW'(T_INIT2 - 1);

  typedef enum logic [2:0] {
    S_PWR_WAIT = 3'd0,
    S_SETUP    = 3'd1,
    S_PULSE    = 3'd2,
    S_HOLD     = 3'd3,
    S_GAP      = 3'd4,
    S_WAIT     = 3'd5,
    S_IDLE     = 3'd6
  } state_t;

  state_t        r_state,     w_state_nx;
  logic [CW-1:0] r_timer,     w_timer_nx;
  logic [1:0]    r_init_idx,  w_init_idx_nx;
  logic          r_init_done, w_init_done_nx;
  logic          r_is_init,   w_is_init_nx;
  logic          r_low,       w_low_nx;
  logic [7:0]    r_byte,      w_byte_nx;
  logic          r_lcd_e;
  logic          r_lcd_rs,    w_lcd_rs_nx;
  logic [3:0]    r_lcd_d,     w_lcd_d_nx;
  logic          r_req_ready;

  logic          w_tmr_zero;
  logic          w_accept;
  logic          w_is_clear;
  logic [CW-1:0] w_wait_len;

  assign w_tmr_zero = (r_timer == '0);
  assign w_accept   = up.req_valid & r_req_ready;
  assign w_is_clear = ~r_lcd_rs & ((r_byte == 8'h01) | (r_byte == 8'h02));

  always_comb begin
    w_wait_len = c_cmd;
    if (r_is_init) begin
      case (r_init_idx)
        2'd0:    w_wait_len = c_init1;
        2'd1:    w_wait_len = c_init2;
        default: w_wait_len = c_cmd;
      endcase
    end else if (w_is_clear) begin
      w_wait_len = c_clear;
    end
  end

  always_comb begin
    w_state_nx     = r_state;
    w_timer_nx     = r_timer;
    w_init_idx_nx  = r_init_idx;
    w_init_done_nx = r_init_done;
    w_is_init_nx   = r_is_init;
    w_low_nx       = r_low;
    w_byte_nx      = r_byte;
    w_lcd_rs_nx    = r_lcd_rs;
    w_lcd_d_nx     = r_lcd_d;

    case (r_state)
      S_PWR_WAIT: begin
        w_timer_nx = r_timer - 1'b1;
        if (w_tmr_zero) begin
          w_state_nx    = S_SETUP;
          w_timer_nx    = c_setup;
          w_is_init_nx  = 1'b1;
          w_init_idx_nx = 2'd0;
          w_lcd_rs_nx   = 1'b0;
          w_lcd_d_nx    = 4'h3;
        end
      end
      S_SETUP: begin
        w_timer_nx = r_timer - 1'b1;
        if (w_tmr_zero) begin
          w_state_nx = S_PULSE;
          w_timer_nx = c_pulse;
        end
      end
      S_PULSE: begin
        w_timer_nx = r_timer - 1'b1;
        if (w_tmr_zero) begin
          w_state_nx = S_HOLD;
          w_timer_nx = c_hold;
        end
      end
      S_HOLD: begin
        w_timer_nx = r_timer - 1'b1;
        if (w_tmr_zero) begin
          if (r_is_init || r_low) begin
            w_state_nx = S_WAIT;
            w_timer_nx = w_wait_len;
          end else begin
            w_state_nx = S_GAP;
            w_timer_nx = c_nibble;
          end
        end
      end
      S_GAP: begin
        w_timer_nx = r_timer - 1'b1;
        if (w_tmr_zero) begin
          w_state_nx = S_SETUP;
          w_timer_nx = c_setup;
          w_low_nx   = 1'b1;
          w_lcd_d_nx = r_byte[3:0];
        end
      end
      S_WAIT: begin
        w_timer_nx = r_timer - 1'b1;
        if (w_tmr_zero) begin
          if (r_is_init && (r_init_idx != 2'd3)) begin
            // The last of the four init nibbles is 0x2 (switch to 4-bit mode).
            w_state_nx    = S_SETUP;
            w_timer_nx    = c_setup;
            w_init_idx_nx = r_init_idx + 2'd1;
            w_lcd_d_nx    = (r_init_idx == 2'd2) ? 4'h2 : 4'h3;
          end else begin
            w_state_nx = S_IDLE;
            if (r_is_init) begin
              w_init_done_nx = 1'b1;
              w_is_init_nx   = 1'b0;
            end
          end
        end
      end
      S_IDLE: begin
        if (w_accept) begin
          w_state_nx  = S_SETUP;
          w_timer_nx  = c_setup;
          w_byte_nx   = up.req_data;
          w_low_nx    = 1'b0;
          w_lcd_rs_nx = up.req_rs;
          w_lcd_d_nx  = up.req_data[7:4];
        end
      end
      default: begin
        w_state_nx = S_PWR_WAIT;
        w_timer_nx = c_powerup;
      end
    endcase
  end

  // Pin outputs are registered from the next-state values so they line up
  // exactly with the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_PWR_WAIT;
      r_timer     <= c_powerup;
      r_init_idx  <= 2'd0;
      r_init_done <= 1'b0;
      r_is_init   <= 1'b0;
      r_low       <= 1'b0;
      r_byte      <= 8'h00;
      r_lcd_e     <= 1'b0;
      r_lcd_rs    <= 1'b0;
      r_lcd_d     <= 4'h0;
      r_req_ready <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_timer     <= w_timer_nx;
      r_init_idx  <= w_init_idx_nx;
      r_init_done <= w_init_done_nx;
      r_is_init   <= w_is_init_nx;
      r_low       <= w_low_nx;
      r_byte      <= w_byte_nx;
      r_lcd_e     <= (w_state_nx == S_PULSE);
      r_lcd_rs    <= w_lcd_rs_nx;
      r_lcd_d     <= w_lcd_d_nx;
      r_req_ready <= (w_state_nx == S_IDLE) & w_init_done_nx;
    end
  end

  assign up.req_ready = r_req_ready;
  assign init_done    = r_init_done;
  assign sf_e         = 1'b1;
  assign lcd_e        = r_lcd_e;
  assign lcd_rs       = r_lcd_rs;
  assign lcd_rw       = 1'b0;
  assign lcd_d        = r_lcd_d;

endmodule

`default_nettype wire
